pipeline_ctrl: RTL and testbench

//  Central sequencer for the 5-stage RISC-V pipeline. Owns every pipeline-register enable and flush.

---
 rtl/pipeline_ctrl_pkg.sv | 51 +++++
 rtl/pipeline_ctrl_perf_counter.sv | 28 ++
 rtl/pipeline_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
//   Shared definitions for the pipeline sequencer. Holds the state
//   encodings, the bundle of enable/flush controls, and the priority
//   decoder for the normal-flow hazard rules. RUN uses these rules directly;
//   DMEM_WAIT reuses them on the cycle the data access completes.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DMEM_WAIT = 2'd1,
    ST_HALT      = 2'd2,
    ST_FAULT     = 2'd3
  } state_t;

  // Field order matches the output port order of pipeline_ctrl.
  typedef struct packed {
    logic pc_write;
    logic if_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
  } ctrl_t;

  // Freeze: every enable low, every flush low.
  localparam ctrl_t CTRL_FREEZE = ctrl_t'(6'b000000);
  // Reset: enables low, both front-end registers flushed.
  localparam ctrl_t CTRL_RESET  = ctrl_t'(6'b001100);

  // Hazard priority for a cycle in which the pipeline may move:
  // load-use stall, then redirect, then instruction-fetch miss, then advance.
  function automatic ctrl_t run_rules(input logic stall,
                                      input logic branch,
                                      input logic jump,
                                      input logic imem_ready);
    ctrl_t c;
    if (stall)
      // Branch operands are stale while the load-use bubble is inserted,
      // so the redirect waits for the next cycle.
      c = ctrl_t'(6'b000111);
    else if (branch || jump)
      c = ctrl_t'(6'b111011);
    else if (!imem_ready)
      // Hold PC, feed a NOP into ID; the back end keeps draining.
      c = ctrl_t'(6'b001011);
    else
      c = ctrl_t'(6'b110011);
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_perf_counter.sv
// perf_counter
//   Free-running event counter, wraps modulo 2^CNT_W.
// Ports:
//   clk    system clock
//   rst    synchronous active-high clear
//   inc    count this cycle
//   count  current value
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst)
      r_count <= '0;
    else if (inc)
      r_count <= r_count + 1'b1;
  end

  assign count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Central sequencer for a 5-stage RISC-V pipeline. Resolves load-use
//   stalls, branch/jump redirects and instruction-fetch misses by fixed
//   priority, sequences multi-cycle data-memory waits with a timeout fault,
//   supports halt/resume, and keeps cycle/stall/flush performance counters.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   Stall, Branch, Jump         ID-stage hazard / redirect requests
//   imem_ready, dmem_req,
//   dmem_ready                  memory handshakes
//   halt_req, resume            halt entry (ecall in WB) / exit
//   PCWrite, IFWrite            PC and IF/ID load enables
//   IFID_flush, IDEX_flush      bubble insertion
//   EXMEM_en, MEMWB_en          back-end load enables
//   halted, fault               state indicators
//   cycle_cnt, stall_cnt,
//   flush_cnt                   performance counters
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Stall,
  input  logic             Branch,
  input  logic             Jump,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  input  logic             resume,
  output logic             PCWrite,
  output logic             IFWrite,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             EXMEM_en,
  output logic             MEMWB_en,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);

  state_t             r_state;
  logic [WAIT_W-1:0]  r_wait_cnt;

  state_t             w_state_nxt;
  logic [WAIT_W-1:0]  w_wait_nxt;
  ctrl_t              w_ctrl;
  logic               w_active;

  always_comb begin
    w_ctrl      = CTRL_FREEZE;
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    if (rst) begin
      w_ctrl      = CTRL_RESET;
      w_state_nxt = ST_RUN;
      w_wait_nxt  = '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (halt_req) begin
            w_state_nxt = ST_HALT;
          end else if (dmem_req && !dmem_ready) begin
            w_state_nxt = ST_DMEM_WAIT;
            w_wait_nxt  = WAIT_W'(1);
          end else begin
            w_ctrl = run_rules(Stall, Branch, Jump, imem_ready);
          end
        end
        ST_DMEM_WAIT: begin
          if (dmem_ready) begin
            // Completing cycle moves straight on under the normal rules.
            w_ctrl      = run_rules(Stall, Branch, Jump, imem_ready);
            w_state_nxt = ST_RUN;
          end else if (r_wait_cnt == WAIT_W'(WAIT_MAX)) begin
            w_state_nxt = ST_FAULT;
          end else begin
            w_wait_nxt = r_wait_cnt + 1'b1;
          end
        end
        ST_HALT: begin
          if (resume)
            w_state_nxt = ST_RUN;
        end
        ST_FAULT: begin
          w_state_nxt = ST_FAULT;
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  assign PCWrite    = w_ctrl.pc_write;
  assign IFWrite    = w_ctrl.if_write;
  assign IFID_flush = w_ctrl.ifid_flush;
  assign IDEX_flush = w_ctrl.idex_flush;
  assign EXMEM_en   = w_ctrl.exmem_en;
  assign MEMWB_en   = w_ctrl.memwb_en;
  assign halted     = !rst && (r_state == ST_HALT);
  assign fault      = !rst && (r_state == ST_FAULT);

  // Only RUN and DMEM_WAIT count as live pipeline cycles.
  assign w_active = !rst && ((r_state == ST_RUN) || (r_state == ST_DMEM_WAIT));

  perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_active),
    .count (cycle_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_active && !w_ctrl.pc_write),
    .count (stall_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!rst && (w_ctrl.ifid_flush || w_ctrl.idex_flush)),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
//   Directed bench for pipeline_ctrl. Control outputs are compared as a
//   6-bit vector {PCWrite, IFWrite, IFID_flush, IDEX_flush, EXMEM_en,
//   MEMWB_en}; counters and state flags are compared individually.
module tb_pipeline_ctrl;

  localparam int CNT_W = 32;

  logic             clk;
  logic             rst;
  logic             Stall, Branch, Jump, imem_ready;
  logic             dmem_req, dmem_ready, halt_req, resume;
  logic             PCWrite, IFWrite, IFID_flush, IDEX_flush, EXMEM_en, MEMWB_en;
  logic             halted, fault;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_ctrl #(.WAIT_MAX(16), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .Stall      (Stall),
    .Branch     (Branch),
    .Jump       (Jump),
    .imem_ready (imem_ready),
    .dmem_req   (dmem_req),
    .dmem_ready (dmem_ready),
    .halt_req   (halt_req),
    .resume     (resume),
    .PCWrite    (PCWrite),
    .IFWrite    (IFWrite),
    .IFID_flush (IFID_flush),
    .IDEX_flush (IDEX_flush),
    .EXMEM_en   (EXMEM_en),
    .MEMWB_en   (MEMWB_en),
    .halted     (halted),
    .fault      (fault),
    .cycle_cnt  (cycle_cnt),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control vectors, {PC, IF, IFIDf, IDEXf, EXMEM, MEMWB}.
  localparam logic [5:0] V_RESET  = 6'b001100;
  localparam logic [5:0] V_FREEZE = 6'b000000;
  localparam logic [5:0] V_ADV    = 6'b110011;
  localparam logic [5:0] V_STALL  = 6'b000111;
  localparam logic [5:0] V_REDIR  = 6'b111011;
  localparam logic [5:0] V_IMISS  = 6'b001011;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ctrl_vec();
    return {26'd0, PCWrite, IFWrite, IFID_flush, IDEX_flush, EXMEM_en, MEMWB_en};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Stall = 0; Branch = 0; Jump = 0; imem_ready = 1;
    dmem_req = 0; dmem_ready = 0; halt_req = 0; resume = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1;
    #1;

    // T1: reset held 3 cycles with Branch asserted
    Branch = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t1_rst_ctrl", ctrl_vec(), {26'd0, V_RESET});
      chk("t1_rst_halted", {31'd0, halted}, 32'd0);
      chk("t1_rst_fault", {31'd0, fault}, 32'd0);
      tick();
      chk("t1_cycle_cnt", cycle_cnt, 32'd0);
      chk("t1_flush_cnt", flush_cnt, 32'd0);
    end
    rst = 0; Branch = 0;
    #1;
    chk("t1_run_after_rst", ctrl_vec(), {26'd0, V_ADV});
    tick();
    chk("t1_cycle_after", cycle_cnt, 32'd1);

    // T2: Stall beats Branch, then Branch alone squashes IF/ID
    do_reset();
    Stall = 1; Branch = 1;
    #1;
    chk("t2_stall_over_br", ctrl_vec(), {26'd0, V_STALL});
    tick();
    Stall = 0;
    #1;
    chk("t2_branch", ctrl_vec(), {26'd0, V_REDIR});
    tick();
    Branch = 0;
    chk("t2_flush_cnt", flush_cnt, 32'd2);
    chk("t2_stall_cnt", stall_cnt, 32'd1);
    chk("t2_cycle_cnt", cycle_cnt, 32'd2);

    // T3: data memory busy for 4 cycles, completes on the 5th
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_freeze", ctrl_vec(), {26'd0, V_FREEZE});
      tick();
    end
    dmem_ready = 1;
    #1;
    chk("t3_complete", ctrl_vec(), {26'd0, V_ADV});
    tick();
    dmem_req = 0; dmem_ready = 0;
    chk("t3_stall_cnt", stall_cnt, 32'd4);
    chk("t3_cycle_cnt", cycle_cnt, 32'd5);
    chk("t3_flush_cnt", flush_cnt, 32'd0);
    #1;
    chk("t3_back_in_run", ctrl_vec(), {26'd0, V_ADV});

    // T4: data memory never answers -> FAULT after 17 cycles
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 16; i++) tick();
    chk("t4_no_fault_yet", {31'd0, fault}, 32'd0);
    tick();
    chk("t4_fault", {31'd0, fault}, 32'd1);
    chk("t4_fault_freeze", ctrl_vec(), {26'd0, V_FREEZE});
    chk("t4_stall_cnt", stall_cnt, 32'd17);
    chk("t4_cycle_cnt", cycle_cnt, 32'd17);
    resume = 1; dmem_req = 0;
    tick();
    resume = 0;
    chk("t4_resume_ignored", {31'd0, fault}, 32'd1);
    rst = 1;
    #1;
    chk("t4_rst_ctrl", ctrl_vec(), {26'd0, V_RESET});
    chk("t4_rst_fault_low", {31'd0, fault}, 32'd0);
    tick();
    rst = 0;
    #1;
    chk("t4_fault_cleared", {31'd0, fault}, 32'd0);
    chk("t4_run_after_rst", ctrl_vec(), {26'd0, V_ADV});

    // T5: halt and resume
    do_reset();
    tick();
    tick();
    chk("t5_cycle_pre", cycle_cnt, 32'd2);
    halt_req = 1;
    #1;
    chk("t5_halt_freeze", ctrl_vec(), {26'd0, V_FREEZE});
    tick();
    halt_req = 0; Branch = 1; Stall = 1;
    #1;
    chk("t5_halted", {31'd0, halted}, 32'd1);
    chk("t5_halt_ignores", ctrl_vec(), {26'd0, V_FREEZE});
    chk("t5_cycle_halt", cycle_cnt, 32'd3);
    tick();
    tick();
    chk("t5_cycle_frozen", cycle_cnt, 32'd3);
    chk("t5_stall_halt", stall_cnt, 32'd1);
    Branch = 0; Stall = 0; resume = 1;
    tick();
    resume = 0;
    chk("t5_resumed", {31'd0, halted}, 32'd0);
    #1;
    chk("t5_run_ctrl", ctrl_vec(), {26'd0, V_ADV});
    tick();
    chk("t5_cycle_continues", cycle_cnt, 32'd4);

    // T6: redirect wins over fetch miss, then fetch miss alone
    do_reset();
    imem_ready = 0; Jump = 1;
    #1;
    chk("t6_jump_over_imiss", ctrl_vec(), {26'd0, V_REDIR});
    tick();
    Jump = 0;
    #1;
    chk("t6_imiss", ctrl_vec(), {26'd0, V_IMISS});
    tick();
    imem_ready = 1;
    chk("t6_stall_cnt", stall_cnt, 32'd1);
    chk("t6_flush_cnt", flush_cnt, 32'd2);
    chk("t6_cycle_cnt", cycle_cnt, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
